// File: rtl/mult_pkg.sv
// Shared types and default widths for the multiplier result accumulator.
// The top takes its widths as parameters; these are the defaults it uses.
package mult_pkg;

    localparam int SIZE_DEF  = 8;
    localparam int GUARD_DEF = 4;
    localparam int LEN_W_DEF = 8;
    localparam int ACC_W     = 2*SIZE_DEF + GUARD_DEF;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/mult_accum_rise_detect.sv
// Rising-edge detector for a level "done" flag.
// o_rise is high in the first cycle i_d is seen high.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_prev <= 1'b0;
        else       r_prev <= i_d;
    end

    assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/mult_accum.sv
// Sums groups of LEN multiplier products and hands each finished sum out over
// a valid/ready handshake, holding off the operand source while a sum is stalled.
module mult_accum
    import mult_pkg::*;
#(
    parameter int size  = SIZE_DEF,
    parameter int GUARD = GUARD_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic                    CLOCK,
    input  logic                    RESET,
    input  logic                    CLEAR,
    input  logic                    END_MULT,
    input  logic [2*size-1:0]       S,
    input  logic [LEN_W-1:0]        LEN,
    output logic [2*size+GUARD-1:0] ACC,
    output logic                    ACC_VALID,
    input  logic                    ACC_READY,
    output logic                    HOLD_START,
    output logic                    BUSY,
    output logic                    OVERFLOW,
    output logic                    DROPPED
);

    localparam int W_ACC = 2*size + GUARD;
    localparam int W_SUM = W_ACC + 1;

    state_t            r_state, w_state_nxt;
    logic [W_ACC-1:0]  r_acc, w_acc_nxt;
    logic [LEN_W-1:0]  r_len, w_len_nxt;
    logic [LEN_W-1:0]  r_cnt, w_cnt_nxt;
    logic [LEN_W-1:0]  w_cnt_inc, w_len_eff;
    logic              r_ovf, w_ovf_nxt;
    logic              r_drop, w_drop_nxt;
    logic              r_valid, r_hold, r_busy;
    logic              w_evt, w_start;
    logic [W_SUM-1:0]  w_sum;

    rise_detect u_rise (
        .i_clk  (CLOCK),
        .i_rst  (RESET),
        .i_d    (END_MULT),
        .o_rise (w_evt)
    );

    assign w_len_eff = (LEN == '0) ? LEN_W'(1) : LEN;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_sum     = {1'b0, r_acc} + W_SUM'(S);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_drop_nxt  = r_drop;
        w_start     = 1'b0;

        case (r_state)
            IDLE:  w_start = w_evt;
            ACCUM: begin
                if (w_evt) begin
                    w_acc_nxt = w_sum[W_ACC-1:0];
                    w_ovf_nxt = r_ovf | w_sum[W_ACC];
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == r_len) w_state_nxt = DONE;
                end
            end
            DONE: begin
                // A product arriving with the handshake opens the next group.
                if (ACC_READY) begin
                    w_state_nxt = IDLE;
                    w_start     = w_evt;
                end else if (w_evt) begin
                    w_drop_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_start) begin
            w_acc_nxt   = W_ACC'(S);
            w_len_nxt   = w_len_eff;
            w_cnt_nxt   = LEN_W'(1);
            w_state_nxt = (w_len_eff == LEN_W'(1)) ? DONE : ACCUM;
        end

        if (CLEAR) begin
            w_state_nxt = IDLE;
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_drop_nxt  = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= 1'b0;
            r_valid <= 1'b0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop here samples pre-edge values.
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ovf   <= w_ovf_nxt;
            r_drop  <= w_drop_nxt;
            r_valid <= (w_state_nxt == DONE);
            r_hold  <= (w_state_nxt == DONE);
            r_busy  <= (w_state_nxt == ACCUM);
        end
    end

    assign ACC        = r_acc;
    assign ACC_VALID  = r_valid;
    assign HOLD_START = r_hold;
    assign BUSY       = r_busy;
    assign OVERFLOW   = r_ovf;
    assign DROPPED    = r_drop;

endmodule

// File: doc/mult_accum.md
Name: mult_accum

Overview:
- Downstream consumer of the shift-and-add multiplier.
- Captures each finished product on the multiplier's END_MULT and accumulates a group of LEN products into a widened sum, giving a dot-product / MAC result.
- Presents each finished sum on a valid/ready output handshake.
- Drives HOLD_START back to the operand source so no new multiplication is started while a result is stalled.

Parameters:
- size, 8, operand width of the multiplier; products are 2*size bits.
- GUARD, 4, extra accumulator bits above 2*size.
- LEN_W, 8, width of the group-length input.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- CLEAR  input  1  synchronous abort; discards the group in progress and clears flags.
- END_MULT  input  1  multiplier done indicator; treated as a level.
- S  input  2*size  multiplier product; valid whenever END_MULT is high.
- LEN  input  LEN_W  products per group; LEN=0 is treated as 1.
- ACC  output  2*size+GUARD  accumulated sum.
- ACC_VALID  output  1  ACC holds a complete group.
- ACC_READY  input  1  consumer accepts ACC.
- HOLD_START  output  1  high = upstream must not assert START.
- BUSY  output  1  group in progress (state ACCUM).
- OVERFLOW  output  1  sticky; accumulator carry-out occurred.
- DROPPED  output  1  sticky; a product arrived while ACC_VALID was high and was discarded.

Behaviour:
- Reset (asynchronous, active-high): ACC=0, ACC_VALID=0, HOLD_START=0, BUSY=0, OVERFLOW=0, DROPPED=0, count=0, state=IDLE, END_MULT history register=0.
- Product event: rising edge of END_MULT, i.e. END_MULT=1 this cycle and 0 in the previous cycle.
  - S is sampled in the same cycle as the event.
  - A held-high END_MULT counts exactly once.
- States: IDLE, ACCUM, DONE.
- IDLE, on event:
  - ACC <= zero-extended S; len_q <= max(LEN,1); count <= 1.
  - Next state is DONE if len_q==1, otherwise ACCUM.
- ACCUM, on event:
  - ACC <= ACC + S, unsigned, modulo 2^(2*size+GUARD).
  - A carry-out sets OVERFLOW; ACC wraps and is not saturated.
  - count <= count+1; go to DONE when count+1==len_q.
- DONE:
  - ACC_VALID=1 and HOLD_START=1; ACC is stable.
  - On ACC_VALID & ACC_READY: the transfer completes at that edge and the next state is IDLE.
  - ACC keeps its value until the first product of the next group.
- Latency: ACC and ACC_VALID update one clock after the event cycle. The final product of a group is visible on ACC with ACC_VALID=1 on the next cycle.
- Event in DONE without handshake: product discarded, DROPPED set, ACC unchanged.
- Event in DONE with handshake in the same cycle: the result transfers and the product becomes the first product of a new group (IDLE-entry rules). ACC_VALID drops for one cycle unless len_q==1.
- ACC_READY in IDLE or ACCUM: ignored.
- LEN is latched only at group start; changes mid-group have no effect.
- CLEAR:
  - Highest synchronous priority, above events and handshakes.
  - Next cycle: state=IDLE, ACC=0, ACC_VALID=0, count=0, OVERFLOW=0, DROPPED=0.
  - An event in the CLEAR cycle is discarded.
- Reset mid-group: immediate return to reset values; the partial sum is lost.
- BUSY=1 exactly in ACCUM. HOLD_START=1 exactly in DONE.
- All outputs are registered.

Decomposition:
- Package mult_pkg: state enum (IDLE, ACCUM, DONE) and localparam ACC_W = 2*size+GUARD.
- Sub-module rise_detect:
  - 1-bit registered rising-edge detector with asynchronous reset, producing the product-event pulse.
  - Reusable by other multiplier consumers.

Test Plan:
- size=8, LEN=3, products 200*200=40000, 255*255=65025, 3*7=21, READY held 1 → ACC=105046 (0x19A56), ACC_VALID high one cycle, OVERFLOW=0.
- LEN=0, single product 0x1234 → treated as LEN=1; ACC=0x1234 with ACC_VALID one cycle after the event.
- GUARD=0, LEN=2, products 0xFFFF then 0x0002 → ACC=0x0001, OVERFLOW=1 and sticky until CLEAR.
- READY=0 after the group completes, then a third END_MULT rise with S=5 → ACC unchanged, DROPPED=1, HOLD_START=1. Raise READY together with the next event, S=9, LEN=1 → old ACC transfers, then ACC=9 with ACC_VALID=1.
- END_MULT held high 4 cycles with S=10, LEN=2 → counted once; BUSY=1, ACC=10, no ACC_VALID.
- LEN=4, after 2 products assert CLEAR, and separately assert RESET asynchronously mid-group → ACC=0, state IDLE, flags cleared. The next 4 products form a fresh, correct sum.
